flow_rank_store: RTL and testbench
==================================

Name: flow_rank_store

Overview:
Per-flow (rank, value) FIFO storage for the PIFO scheduler datapath. Entries are kept in arrival order within each flow. The scheduler reads a peek of every flow's head rank and pops a chosen flow with a one-cycle-latency read. This block generalises the single-width, one-hot-flow rank store in several ways:
- rank, value, depth and flow count are all parametrised;
- flows are selected by binary index;
- each flow has its own occupancy counter and full/empty flags;
- overflow and underflow are explicitly rejected and reported;
- an empty-flow push+pop bypasses storage.

Parameters:
- FLOWS, 10: number of independent flow queues.
- DEPTH, 50: entries per flow. Any value ≥2; need not be a power of two.
- RANK_W, 32: rank width in bits.
- VALUE_W, 32: value width in bits.
- FLOW_W, $clog2(FLOWS): width of a flow index.
- CNT_W, $clog2(DEPTH+1): width of a per-flow occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- push  in  1  enqueue request this cycle.
- push_flow  in  FLOW_W  target flow index of the push.
- push_rank  in  RANK_W  rank to store.
- push_value  in  VALUE_W  value to store.
- push_drop  out  1  registered pulse: the previous cycle's push was rejected.
- pop  in  1  dequeue request this cycle.
- pop_flow  in  FLOW_W  flow index to dequeue.
- pop_rank  out  RANK_W  registered rank of the popped entry.
- pop_value  out  VALUE_W  registered value of the popped entry.
- pop_valid  out  1  registered: pop_rank/pop_value are valid this cycle.
- pop_err  out  1  registered pulse: the previous cycle's pop was rejected.
- head_rank  out  FLOWS*RANK_W  combinational; flow i's head rank in bits [i*RANK_W +: RANK_W]; 0 when flow i is empty.
- flow_empty  out  FLOWS  combinational; bit i = count[i]==0.
- flow_full  out  FLOWS  combinational; bit i = count[i]==DEPTH.
- total_count  out  $clog2(FLOWS*DEPTH+1)  registered sum of all flow occupancies.

Behaviour:
- State per flow: head pointer, tail pointer (binary, 0..DEPTH-1), count (CNT_W bits). Plus the storage arrays and the registered outputs.
- Reset (rst==0 at a clock edge):
  - all head/tail pointers and counts go to 0;
  - pop_valid, pop_err and push_drop go to 0; pop_rank and pop_value go to 0; total_count goes to 0;
  - storage contents are don't-care;
  - push/pop in a reset cycle are ignored;
  - reset mid-operation discards all queued entries; the next cycle sees every flow empty.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. Otherwise it increments by 1.
- Push accepted iff push==1, push_flow<FLOWS, and the flow is not full. The "not full" condition is relaxed when the same cycle also has an accepted pop on the same flow (see "Simultaneous push and pop" below).
  - Accepted push: write storage[flow][tail], advance tail, increment count.
  - Rejected push (full, or push_flow≥FLOWS): no state change; push_drop=1 next cycle.
- Pop accepted iff pop==1, pop_flow<FLOWS, and count[pop_flow]>0.
  - Accepted pop: next cycle pop_valid=1 and pop_rank/pop_value = entry at head (sampled at the pop edge); advance head, decrement count.
  - Rejected pop: next cycle pop_valid=0 and pop_err=1; pop_rank/pop_value hold their previous values.
- Pop latency is exactly 1 cycle. pop_valid is 0 in every cycle not following an accepted pop. There is no backpressure on the pop outputs.
- Simultaneous push and pop, different flows: each is handled independently.
- Simultaneous push and pop, same flow:
  - count>0: both accepted; the popped entry is the old head; count is unchanged. This includes a full flow, which stays full.
  - count==0 (bypass): the pushed rank/value appear on pop_rank/pop_value next cycle with pop_valid=1. Storage, pointers and count are unchanged. pop_err=0 and push_drop=0.
- total_count update per cycle: +1 per accepted non-bypass push, −1 per accepted non-bypass pop. A bypass contributes 0.
- Flags: head_rank, flow_empty and flow_full reflect state after the last clock edge. Same-cycle push/pop do not affect them.

Test Plan:
- Reset with rst=0 for 2 cycles, then release -> flow_empty=all 1s, flow_full=0, total_count=0, pop_valid=0, head_rank all 0.
- Push ranks 5,3,9 to flow 2 on consecutive cycles; pop flow 2 three times -> pop_rank 5,3,9 each 1 cycle after its pop; head_rank[2] goes 5→3→9→0; flow_empty[2] is 1 after the last pop.
- With DEPTH=4: push ranks 1..4 to flow 0 -> flow_full[0]=1. Push rank 5 -> push_drop=1 and count is unchanged. Pop 4 times -> ranks 1,2,3,4. Push/pop 10 more entries -> FIFO order is preserved across pointer wrap.
- Pop an empty flow 7 -> pop_valid=0, pop_err=1 next cycle, no state change. Push+pop on empty flow 7 with rank 42 -> pop_rank=42, pop_valid=1, flow_empty[7] stays 1, total_count unchanged.
- Flow 0 full (DEPTH=4): push rank 8 and pop flow 0 in the same cycle -> pop returns the old head, push accepted, flow_full[0] stays 1, order preserved.
- Reset asserted while flows 1 and 3 hold entries and a pop is issued -> pop_valid=0 next cycle, all flows empty, total_count=0.

Source files
------------

// File: rtl/flow_rank_store.sv
// rtl/flow_rank_store.sv - per-flow (rank, value) FIFO store with head-rank peek and one-cycle pop
module flow_rank_store #(
    parameter int FLOWS   = 10,
    parameter int DEPTH   = 50,
    parameter int RANK_W  = 32,
    parameter int VALUE_W = 32,
    parameter int FLOW_W  = $clog2(FLOWS),
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [FLOW_W-1:0]                 push_flow,
    input  logic [RANK_W-1:0]                 push_rank,
    input  logic [VALUE_W-1:0]                push_value,
    output logic                              push_drop,
    input  logic                              pop,
    input  logic [FLOW_W-1:0]                 pop_flow,
    output logic [RANK_W-1:0]                 pop_rank,
    output logic [VALUE_W-1:0]                pop_value,
    output logic                              pop_valid,
    output logic                              pop_err,
    output logic [FLOWS*RANK_W-1:0]           head_rank,
    output logic [FLOWS-1:0]                  flow_empty,
    output logic [FLOWS-1:0]                  flow_full,
    output logic [$clog2(FLOWS*DEPTH+1)-1:0]  total_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int TOT_W = $clog2(FLOWS * DEPTH + 1);
    localparam int LAST  = DEPTH - 1;
    localparam logic [FLOW_W:0]  FLOWS_LIM = FLOWS[FLOW_W:0];
    localparam logic [CNT_W-1:0] DEPTH_CNT = DEPTH[CNT_W-1:0];
    localparam logic [PTR_W-1:0] LAST_PTR  = LAST[PTR_W-1:0];

    logic [RANK_W-1:0]  rank_mem  [FLOWS][DEPTH];
    logic [VALUE_W-1:0] value_mem [FLOWS][DEPTH];
    logic [PTR_W-1:0]   head [FLOWS];
    logic [PTR_W-1:0]   tail [FLOWS];
    logic [CNT_W-1:0]   count [FLOWS];

    logic               push_in_range;
    logic               pop_in_range;
    logic               same_flow;
    logic [CNT_W-1:0]   push_cnt;
    logic [CNT_W-1:0]   pop_cnt;
    logic [PTR_W-1:0]   push_tail;
    logic [PTR_W-1:0]   pop_head;
    logic               pop_acc;
    logic               push_acc;
    logic               bypass;
    logic               push_hit [FLOWS];
    logic               pop_hit  [FLOWS];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_in_range = {1'b0, push_flow} < FLOWS_LIM;
    assign pop_in_range  = {1'b0, pop_flow} < FLOWS_LIM;
    assign same_flow     = (push_flow == pop_flow);

    // Per-flow state is only looked up for in-range indices.
    always_comb begin
        push_cnt  = '0;
        push_tail = '0;
        pop_cnt   = '0;
        pop_head  = '0;
        if (push_in_range) begin
            push_cnt  = count[push_flow];
            push_tail = tail[push_flow];
        end
        if (pop_in_range) begin
            pop_cnt  = count[pop_flow];
            pop_head = head[pop_flow];
        end
    end

    assign pop_acc  = pop && pop_in_range && (pop_cnt != '0);
    assign bypass   = push && push_in_range && pop && pop_in_range && same_flow && (pop_cnt == '0);
    // A full flow still takes a push when the same cycle pops it.
    assign push_acc = push && push_in_range && !bypass &&
                      ((push_cnt != DEPTH_CNT) || (pop_acc && same_flow));

    always_comb begin
        for (int i = 0; i < FLOWS; i++) begin
            push_hit[i] = push_acc && (push_flow == FLOW_W'(i));
            pop_hit[i]  = pop_acc && (pop_flow == FLOW_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FLOWS; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FLOWS; i++) begin
                if (pop_hit[i]) begin
                    head[i] <= next_ptr(head[i]);
                end
                if (push_hit[i]) begin
                    tail[i] <= next_ptr(tail[i]);
                end
                if (push_hit[i] && !pop_hit[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (pop_hit[i] && !push_hit[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    // Storage is not reset; occupancy counters decide what is live.
    always_ff @(posedge clk) begin
        if (rst && push_acc) begin
            rank_mem[push_flow][push_tail]  <= push_rank;
            value_mem[push_flow][push_tail] <= push_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pop_valid   <= 1'b0;
            pop_err     <= 1'b0;
            push_drop   <= 1'b0;
            pop_rank    <= '0;
            pop_value   <= '0;
            total_count <= '0;
        end else begin
            pop_valid <= pop_acc || bypass;
            pop_err   <= pop && !pop_acc && !bypass;
            push_drop <= push && !push_acc && !bypass;
            if (pop_acc) begin
                pop_rank  <= rank_mem[pop_flow][pop_head];
                pop_value <= value_mem[pop_flow][pop_head];
            end else if (bypass) begin
                pop_rank  <= push_rank;
                pop_value <= push_value;
            end
            if (push_acc && !pop_acc) begin
                total_count <= total_count + TOT_W'(1);
            end else if (pop_acc && !push_acc) begin
                total_count <= total_count - TOT_W'(1);
            end
        end
    end

    always_comb begin
        head_rank  = '0;
        flow_empty = '0;
        flow_full  = '0;
        for (int i = 0; i < FLOWS; i++) begin
            flow_empty[i] = (count[i] == '0);
            flow_full[i]  = (count[i] == DEPTH_CNT);
            if (count[i] != '0) begin
                head_rank[i*RANK_W +: RANK_W] = rank_mem[i][head[i]];
            end
        end
    end

endmodule

// File: tb/tb_flow_rank_store.sv
// tb/tb_flow_rank_store.sv - directed and randomized checks of flow_rank_store against a queue model
module tb_flow_rank_store;

    localparam int FLOWS = 10;
    localparam int DEPTH = 4;
    localparam int RW    = 16;
    localparam int VW    = 16;
    localparam int FW    = $clog2(FLOWS);
    localparam int TW    = $clog2(FLOWS * DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 push = 1'b0;
    logic [FW-1:0]        push_flow = '0;
    logic [RW-1:0]        push_rank = '0;
    logic [VW-1:0]        push_value = '0;
    logic                 push_drop;
    logic                 pop = 1'b0;
    logic [FW-1:0]        pop_flow = '0;
    logic [RW-1:0]        pop_rank;
    logic [VW-1:0]        pop_value;
    logic                 pop_valid;
    logic                 pop_err;
    logic [FLOWS*RW-1:0]  head_rank;
    logic [FLOWS-1:0]     flow_empty;
    logic [FLOWS-1:0]     flow_full;
    logic [TW-1:0]        total_count;

    flow_rank_store #(
        .FLOWS(FLOWS), .DEPTH(DEPTH), .RANK_W(RW), .VALUE_W(VW)
    ) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_flow(push_flow), .push_rank(push_rank), .push_value(push_value),
        .push_drop(push_drop),
        .pop(pop), .pop_flow(pop_flow), .pop_rank(pop_rank), .pop_value(pop_value),
        .pop_valid(pop_valid), .pop_err(pop_err),
        .head_rank(head_rank), .flow_empty(flow_empty), .flow_full(flow_full),
        .total_count(total_count)
    );

    always #5 clk = ~clk;

    logic [31:0]   mq [FLOWS][$];
    logic          exp_valid, exp_err, exp_drop;
    logic [RW-1:0] exp_rank;
    logic [VW-1:0] exp_value;
    int            checks = 0;
    int            errors = 0;

    function automatic int model_total();
        int s = 0;
        for (int i = 0; i < FLOWS; i++) s += mq[i].size();
        return s;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        for (int i = 0; i < FLOWS; i++) mq[i].delete();
        exp_valid = 0; exp_err = 0; exp_drop = 0; exp_rank = '0; exp_value = '0;
        rst = 1'b1;
    endtask

    // Drives one cycle of stimulus and advances the queue model; returns #1 after the edge.
    task automatic cycle(input bit p, input int pf, input int pr, input int pv,
                         input bit po, input int of);
        logic [31:0] e;
        bit pin, oin, byp, pok;
        pin = (pf < FLOWS);
        oin = (of < FLOWS);
        push = p; push_flow = FW'(pf); push_rank = RW'(pr); push_value = VW'(pv);
        pop = po; pop_flow = FW'(of);
        byp = 0; pok = 0;
        if (po && oin) begin
            if (mq[of].size() > 0) pok = 1;
            else if (p && pin && pf == of) byp = 1;
        end
        exp_valid = pok || byp;
        exp_err   = po && !pok && !byp;
        exp_drop  = 0;
        if (pok) begin
            e = mq[of].pop_front();
            exp_rank = e[31:16]; exp_value = e[15:0];
        end else if (byp) begin
            exp_rank = RW'(pr); exp_value = VW'(pv);
        end
        if (p && !byp) begin
            if (pin) begin
                if (mq[pf].size() < DEPTH) mq[pf].push_back({RW'(pr), VW'(pv)});
                else exp_drop = 1;
            end else begin
                exp_drop = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        push = 1; push_flow = 0; push_rank = 16'd77; pop = 1; pop_flow = 0;
        do_reset(2);
        push = 0; pop = 0;
        checks++; if (flow_empty !== {FLOWS{1'b1}}) begin errors++; $display("FAIL reset_empty got %h exp all ones", flow_empty); end
        checks++; if (flow_full !== '0) begin errors++; $display("FAIL reset_full got %h exp 0", flow_full); end
        checks++; if (total_count !== '0) begin errors++; $display("FAIL reset_total got %0d exp 0", total_count); end
        checks++; if (pop_valid !== 1'b0 || pop_err !== 1'b0 || push_drop !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got v=%b e=%b d=%b exp 0", pop_valid, pop_err, push_drop); end
        checks++; if (head_rank !== '0) begin errors++; $display("FAIL reset_head got %h exp 0", head_rank); end
    endtask

    task automatic test_order();
        int ranks [3] = '{5, 3, 9};
        int heads [3] = '{3, 9, 0};
        for (int k = 0; k < 3; k++) cycle(1, 2, ranks[k], 200 + k, 0, 0);
        checks++; if (head_rank[2*RW +: RW] !== 16'd5) begin errors++; $display("FAIL order_head0 got %0d exp 5", head_rank[2*RW +: RW]); end
        checks++; if (total_count !== TW'(3)) begin errors++; $display("FAIL order_total got %0d exp 3", total_count); end
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 0, 1, 2);
            checks++;
            if (pop_valid !== 1'b1 || pop_rank !== RW'(ranks[k]) || pop_value !== VW'(200 + k)) begin
                errors++; $display("FAIL order_pop%0d got v=%b r=%0d val=%0d exp r=%0d", k, pop_valid, pop_rank, pop_value, ranks[k]); end
            checks++;
            if (head_rank[2*RW +: RW] !== RW'(heads[k])) begin
                errors++; $display("FAIL order_head%0d got %0d exp %0d", k + 1, head_rank[2*RW +: RW], heads[k]); end
        end
        checks++; if (flow_empty[2] !== 1'b1) begin errors++; $display("FAIL order_empty got %b exp 1", flow_empty[2]); end
        idle();
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL order_valid_drop got %b exp 0", pop_valid); end
    endtask

    task automatic test_full_wrap();
        do_reset(1);
        for (int k = 1; k <= 4; k++) cycle(1, 0, k, 100 + k, 0, 0);
        checks++; if (flow_full[0] !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", flow_full[0]); end
        cycle(1, 0, 5, 105, 0, 0);
        checks++; if (push_drop !== 1'b1 || total_count !== TW'(4)) begin
            errors++; $display("FAIL full_drop got d=%b tot=%0d exp d=1 tot=4", push_drop, total_count); end
        for (int k = 1; k <= 4; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            checks++; if (pop_rank !== RW'(k) || pop_value !== VW'(100 + k) || pop_valid !== 1'b1) begin
                errors++; $display("FAIL full_pop got r=%0d val=%0d v=%b exp r=%0d", pop_rank, pop_value, pop_valid, k); end
        end
        cycle(1, 0, 20, 0, 0, 0);
        cycle(1, 0, 21, 1, 0, 0);
        for (int k = 2; k < 10; k++) begin
            cycle(1, 0, 20 + k, k, 1, 0);
            checks++; if (pop_rank !== RW'(18 + k) || pop_valid !== 1'b1 || push_drop !== 1'b0) begin
                errors++; $display("FAIL wrap_pop got r=%0d v=%b exp r=%0d", pop_rank, pop_valid, 18 + k); end
        end
        for (int k = 8; k < 10; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            checks++; if (pop_rank !== RW'(20 + k)) begin
                errors++; $display("FAIL wrap_tail got %0d exp %0d", pop_rank, 20 + k); end
        end
    endtask

    task automatic test_empty_and_bypass();
        logic [RW-1:0] prev_rank;
        int tot;
        prev_rank = exp_rank;
        tot = model_total();
        cycle(0, 0, 0, 0, 1, 7);
        checks++; if (pop_valid !== 1'b0 || pop_err !== 1'b1 || pop_rank !== prev_rank) begin
            errors++; $display("FAIL empty_pop got v=%b e=%b r=%0d exp v=0 e=1 r=%0d", pop_valid, pop_err, pop_rank, prev_rank); end
        cycle(1, 7, 42, 77, 1, 7);
        checks++; if (pop_valid !== 1'b1 || pop_rank !== 16'd42 || pop_value !== 16'd77) begin
            errors++; $display("FAIL bypass_data got v=%b r=%0d val=%0d exp 1/42/77", pop_valid, pop_rank, pop_value); end
        checks++; if (flow_empty[7] !== 1'b1 || total_count !== TW'(tot) || pop_err !== 1'b0 || push_drop !== 1'b0) begin
            errors++; $display("FAIL bypass_state got emp=%b tot=%0d e=%b d=%b exp emp=1 tot=%0d", flow_empty[7], total_count, pop_err, push_drop, tot); end
    endtask

    task automatic test_full_push_pop();
        int order [4] = '{2, 3, 4, 8};
        do_reset(1);
        for (int k = 1; k <= 4; k++) cycle(1, 0, k, k, 0, 0);
        cycle(1, 0, 8, 8, 1, 0);
        checks++; if (pop_rank !== 16'd1 || push_drop !== 1'b0 || flow_full[0] !== 1'b1 || total_count !== TW'(4)) begin
            errors++; $display("FAIL fullpp got r=%0d d=%b full=%b tot=%0d exp 1/0/1/4", pop_rank, push_drop, flow_full[0], total_count); end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, 1, 0);
            checks++; if (pop_rank !== RW'(order[k])) begin
                errors++; $display("FAIL fullpp_order got %0d exp %0d", pop_rank, order[k]); end
        end
    endtask

    task automatic test_bad_flow();
        cycle(1, 3, 11, 11, 0, 0);
        cycle(1, 12, 50, 50, 0, 0);
        checks++; if (push_drop !== 1'b1 || total_count !== TW'(1)) begin
            errors++; $display("FAIL bad_push got d=%b tot=%0d exp d=1 tot=1", push_drop, total_count); end
        cycle(1, 13, 51, 51, 1, 13);
        checks++; if (pop_err !== 1'b1 || pop_valid !== 1'b0 || push_drop !== 1'b1) begin
            errors++; $display("FAIL bad_pop got e=%b v=%b d=%b exp 1/0/1", pop_err, pop_valid, push_drop); end
    endtask

    task automatic test_random();
        logic [FLOWS-1:0]    ee, ef;
        logic [FLOWS*RW-1:0] eh;
        int pf, of;
        for (int n = 0; n < 400; n++) begin
            pf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 3));
            of = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 3));
            cycle($urandom_range(0, 9) < 6, pf, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                  $urandom_range(0, 9) < 5, of);
            ee = '0; ef = '0; eh = '0;
            for (int i = 0; i < FLOWS; i++) begin
                ee[i] = (mq[i].size() == 0);
                ef[i] = (mq[i].size() == DEPTH);
                if (mq[i].size() > 0) eh[i*RW +: RW] = mq[i][0][31:16];
            end
            checks++;
            if (pop_valid !== exp_valid || pop_err !== exp_err || push_drop !== exp_drop) begin
                errors++; $display("FAIL rand_pulses n=%0d got v=%b e=%b d=%b exp v=%b e=%b d=%b",
                                   n, pop_valid, pop_err, push_drop, exp_valid, exp_err, exp_drop); end
            checks++;
            if (pop_rank !== exp_rank || pop_value !== exp_value) begin
                errors++; $display("FAIL rand_data n=%0d got r=%h val=%h exp r=%h val=%h", n, pop_rank, pop_value, exp_rank, exp_value); end
            checks++;
            if (total_count !== TW'(model_total()) || flow_empty !== ee || flow_full !== ef) begin
                errors++; $display("FAIL rand_occ n=%0d got tot=%0d emp=%h full=%h exp tot=%0d emp=%h full=%h",
                                   n, total_count, flow_empty, flow_full, model_total(), ee, ef); end
            checks++;
            if (head_rank !== eh) begin
                errors++; $display("FAIL rand_head n=%0d got %h exp %h", n, head_rank, eh); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        cycle(1, 1, 10, 10, 0, 0);
        cycle(1, 3, 30, 30, 0, 0);
        cycle(1, 1, 11, 11, 0, 0);
        push = 0; pop = 1; pop_flow = 1;
        do_reset(1);
        pop = 0;
        checks++; if (pop_valid !== 1'b0 || flow_empty !== {FLOWS{1'b1}} || total_count !== '0) begin
            errors++; $display("FAIL midreset got v=%b emp=%h tot=%0d exp 0/all/0", pop_valid, flow_empty, total_count); end
        cycle(0, 0, 0, 0, 1, 1);
        checks++; if (pop_err !== 1'b1 || pop_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_pop got e=%b v=%b exp 1/0", pop_err, pop_valid); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_wrap();
        test_empty_and_bypass();
        test_full_push_pop();
        test_bad_flow();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
